// File: rtl/secded_err_monitor.sv
// SECDED error monitor.
// Sits behind a SECDED decoder: forwards clean or corrected words through a
// one-deep output register, counts corrected and uncorrectable words, captures
// the syndrome of the first erroneous word and tracks an OK/DEGRADED/FAULT
// health state with a one-cycle interrupt on every entry into a bad state.
module secded_err_monitor #(
  parameter int K       = 8,
  parameter int M       = 4,
  parameter int CNT_W   = 16,
  parameter int DEG_THR = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [K-1:0]     q_i,
  input  logic [M-1:0]     syndrome_i,
  input  logic             sb_err_i,
  input  logic             db_err_i,
  input  logic             sb_fix_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [K-1:0]     q_o,
  input  logic             clr_i,
  output logic [CNT_W-1:0] sb_cnt_o,
  output logic [CNT_W-1:0] db_cnt_o,
  output logic [M-1:0]     first_syn_o,
  output logic             first_vld_o,
  output logic [1:0]       state_o,
  output logic             irq_o
);

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_FAULT    = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(DEG_THR);

  state_t         state_reg;
  state_t         state_next;
  state_t         state_base;
  logic           valid_reg;
  logic [K-1:0]   q_reg;
  logic           first_vld_reg;
  logic           first_vld_next;
  logic [M-1:0]   first_syn_reg;
  logic [M-1:0]   first_syn_next;
  logic           irq_reg;
  logic           irq_next;
  logic           accept;
  logic           word_db;
  logic           word_sb;
  logic           load_out;
  logic [1:0]     cnt_inc;

  // The decoder's "corrected" flag carries no information beyond sb_err_i
  // for classification purposes; it is deliberately ignored.
  logic unused_sb_fix;
  assign unused_sb_fix = sb_fix_i;

  // Upstream may push when the output slot is free or draining this cycle,
  // never in FAULT and never while reset is held.
  assign ready_o  = rst_ni && (!valid_reg || ready_i) && (state_reg != ST_FAULT);
  assign accept   = valid_i && ready_o;
  // Double-bit wins over single-bit when both are flagged.
  assign word_db  = accept && db_err_i;
  assign word_sb  = accept && !db_err_i && sb_err_i;
  // Uncorrectable data is consumed but never forwarded.
  assign load_out = accept && !db_err_i;
  assign cnt_inc  = {word_db, word_sb};

  // Output register: load on a forwardable word, otherwise drain on handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_reg <= 1'b0;
      q_reg     <= '0;
    end else if (load_out) begin
      valid_reg <= 1'b1;
      q_reg     <= q_i;
    end else if (ready_i) begin
      valid_reg <= 1'b0;
    end
  end

  // Index 0 counts corrected words, index 1 uncorrectable words. A clear
  // zeroes the count first so a word accepted in the same cycle lands on top.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_base;

    // Saturating increment on top of the (optionally cleared) count.
    always_comb begin
      cnt_base = clr_i ? '0 : cnt_reg;
      cnt_next = cnt_base;
      if (cnt_inc[gi] && (cnt_base != CNT_MAX)) begin
        cnt_next = cnt_base + CNT_W'(1);
      end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end
  end

  // First-error capture: only the first erroneous word after a clear sticks.
  always_comb begin
    first_vld_next = clr_i ? 1'b0 : first_vld_reg;
    first_syn_next = clr_i ? '0 : first_syn_reg;
    if ((word_db || word_sb) && !first_vld_next) begin
      first_vld_next = 1'b1;
      first_syn_next = syndrome_i;
    end
  end

  // First-error capture register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      first_vld_reg <= 1'b0;
      first_syn_reg <= '0;
    end else begin
      first_vld_reg <= first_vld_next;
      first_syn_reg <= first_syn_next;
    end
  end

  // Health FSM next state. A clear drops to OK before the current word is
  // applied, so clear plus an uncorrectable word still ends in FAULT.
  always_comb begin
    state_base = clr_i ? ST_OK : state_reg;
    state_next = state_base;
    if (word_db) begin
      state_next = ST_FAULT;
    end else if ((state_base == ST_OK) && word_sb && (g_cnt[0].cnt_next == THR)) begin
      state_next = ST_DEGRADED;
    end
    irq_next = (state_next != state_base) && (state_next != ST_OK);
  end

  // Health FSM state and interrupt registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= ST_OK;
      irq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      irq_reg   <= irq_next;
    end
  end

  assign valid_o     = valid_reg;
  assign q_o         = q_reg;
  assign sb_cnt_o    = g_cnt[0].cnt_reg;
  assign db_cnt_o    = g_cnt[1].cnt_reg;
  assign first_syn_o = first_syn_reg;
  assign first_vld_o = first_vld_reg;
  assign state_o     = state_reg;
  assign irq_o       = irq_reg;

endmodule
